serial_nibble_sub_ctrl: RTL and testbench
=========================================

SERIAL_NIBBLE_SUB_CTRL -- requirements
Module: serial_nibble_sub_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit digits per operand; the operand width W = 4*NIBBLES; legal range 1..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 a  input  W  minuend; captured on the accepted start edge.
REQ-006 b  input  W  subtrahend; captured on the accepted start edge.
REQ-007 bin  input  1  initial borrow-in; captured on the accepted start edge.
REQ-008 busy  output  1  high while in RUN.
REQ-009 done  output  1  one-cycle pulse; high while in DONE.
REQ-010 diff  output  W  result register, a - b - bin modulo 2^W.
REQ-011 bout  output  1  final borrow-out from the most significant digit.
REQ-012 zero  output  1  high when diff == 0; valid while done is high and afterwards.

Function
REQ-013 The block SHALL instantiate exactly one 4-bit ripple_borrow_subtractor (ports A, B, Bin, D, Bout) and time-share it across all digits; there is no other subtraction logic.
REQ-014 FSM states: IDLE, RUN, DONE; all outputs are registered or decoded from registered state only.
REQ-015 IDLE: with start=1 at an edge, capture a, b and bin; clear diff to 0; set idx=0; go to RUN. With start=0, remain in IDLE.
REQ-016 RUN, each edge: apply digit idx of the captured operands and the borrow register to the subtractor; write D into diff[4*idx+3:4*idx]; load the borrow register from Bout; increment idx.
REQ-017 RUN: the edge that processes idx == NIBBLES-1 SHALL load bout with the final Bout, load zero, and go to DONE.
REQ-018 DONE: done=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
REQ-019 Latency: with start sampled at edge E0, done is high from edge E0+NIBBLES to E0+NIBBLES+1. Back-to-back throughput is one operation per NIBBLES+2 cycles.
REQ-020 start is ignored in RUN and DONE. Inputs a, b and bin may change after the accepted edge without affecting the result.
REQ-021 diff, bout and zero hold their values from DONE until the next accepted start.
REQ-022 With NIBBLES=1, RUN lasts one cycle and the behaviour equals one combinational 4-bit subtraction, registered.
REQ-023 idx width is ceil(log2(NIBBLES)) with a minimum of 1; idx never exceeds NIBBLES-1.

Reset
REQ-024 With rst_n=0 at an edge: state goes to IDLE; idx, the borrow register, diff, bout, zero, busy and done all go to 0.
REQ-025 Reset during RUN or DONE aborts the operation with no done pulse; the first start accepted after rst_n returns high behaves as in REQ-015.
REQ-026 Reset has priority over start at the same edge.

Verification
REQ-027 NIBBLES=4, a=0x1234, b=0x0234, bin=0, start pulse -> busy high for 4 cycles, done 4 cycles after the start edge, diff=0x1000, bout=0, zero=0.
REQ-028 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, zero=0 (borrow ripples through all digits).
REQ-029 a=0x0005, b=0x0004, bin=1 -> diff=0x0000, bout=0, zero=1; a=0x1000, b=0x0001 -> diff=0x0FFF, bout=0.
REQ-030 Start held high continuously with changing a/b -> only IDLE-sampled operands are used; done pulses every 6 cycles; each diff matches the operands captured at the corresponding start edge.
REQ-031 rst_n pulled low two cycles into RUN -> no done pulse; all outputs are 0 the next cycle; a new start completes correctly.
REQ-032 Exhaustive run with NIBBLES=1: all 256 {a,b} pairs x bin in {0,1} -> diff = (a-b-bin) mod 16 and bout = (a < b+bin), each checked at done.

Source files
------------

// File: rtl/serial_nibble_sub_ctrl.sv
// rtl/serial_nibble_sub_ctrl.sv - digit-serial subtractor, one shared 4-bit ripple-borrow stage
//
// ripple_borrow_subtractor: 4-bit combinational a - b - borrow.
//   A, B   : 4-bit operands
//   Bin    : borrow in
//   D      : 4-bit difference
//   Bout   : borrow out of the top bit
//
// serial_nibble_sub_ctrl: computes diff = a - b - bin (mod 2^W), W = 4*NIBBLES,
// one 4-bit digit per clock, least significant digit first.
//   clk    : clock, all state on rising edge
//   rst_n  : synchronous active-low reset
//   start  : begin an operation (only looked at while idle)
//   a, b   : minuend / subtrahend, captured with the accepted start
//   bin    : initial borrow, captured with the accepted start
//   busy   : high while digits are being processed
//   done   : single-cycle completion pulse
//   diff   : result register
//   bout   : borrow out of the most significant digit
//   zero   : diff == 0, valid from done onwards

module ripple_borrow_subtractor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Bin,
  output logic [3:0] D,
  output logic       Bout
);

  logic [4:0] brw;

  always_comb begin
    brw[0] = Bin;
    for (int i = 0; i < 4; i++) begin
      D[i]       = A[i] ^ B[i] ^ brw[i];
      // borrow when b+borrow exceeds a at this bit position
      brw[i + 1] = (~A[i] & B[i]) | (~(A[i] ^ B[i]) & brw[i]);
    end
    Bout = brw[4];
  end

endmodule

module serial_nibble_sub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   bin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   diff,
  output logic                   bout,
  output logic                   zero
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          brw;
  logic [W-1:0]  a_cap;
  logic [W-1:0]  b_cap;

  logic [3:0]    a_dig;
  logic [3:0]    b_dig;
  logic [3:0]    d_dig;
  logic          bo_dig;
  logic [W-1:0]  diff_nxt;

  // Digit mux built as a compare-per-digit so that idx codes above
  // NIBBLES-1 (possible in the encoding, never reached) select nothing.
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_dig = a_cap[4*i +: 4];
        b_dig = b_cap[4*i +: 4];
      end
    end
  end

  ripple_borrow_subtractor u_sub (
    .A    (a_dig),
    .B    (b_dig),
    .Bin  (brw),
    .D    (d_dig),
    .Bout (bo_dig)
  );

  // diff with the current digit already merged in; lets zero be loaded on
  // the same edge as the final digit.
  always_comb begin
    diff_nxt = diff;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        diff_nxt[4*i +: 4] = d_dig;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      brw   <= 1'b0;
      a_cap <= '0;
      b_cap <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_cap <= a;
            b_cap <= b;
            brw   <= bin;
            diff  <= '0;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          diff <= diff_nxt;
          brw  <= bo_dig;
          if (idx == LAST_IDX) begin
            bout  <= bo_dig;
            zero  <= (diff_nxt == '0);
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_serial_nibble_sub_ctrl.sv
// tb/tb_serial_nibble_sub_ctrl.sv - self-checking bench for serial_nibble_sub_ctrl

module tb_serial_nibble_sub_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        bin;
  logic        busy, done, bout, zero;
  logic [15:0] diff;

  logic        start1;
  logic [3:0]  a1, b1;
  logic        bin1;
  logic        busy1, done1, bout1, zero1;
  logic [3:0]  diff1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_nibble_sub_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero)
  );

  serial_nibble_sub_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1), .zero(zero1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        z;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operand.
  function automatic logic [15:0] ref_diff(input logic [15:0] x, input logic [15:0] y, input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return 16'(r & 32'hFFFF);
  endfunction

  function automatic logic ref_bout(input logic [15:0] x, input logic [15:0] y, input logic c);
    return int'(x) < (int'(y) + int'(c));
  endfunction

  // One operation on the 4-digit unit; inputs are scrambled right after the
  // accepted edge to show the captured copies are what gets used.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        output logic [15:0] gd, output logic gb, output logic gz,
                        output int lat, output int bcnt, output logic seen);
    @(negedge clk);
    a = ta; b = tb; bin = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    lat = -1; bcnt = 0; seen = 1'b0;
    gd = '0; gb = 1'b0; gz = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        seen = 1'b1;
        lat  = c - 1;
        gd = diff; gb = bout; gz = zero;
      end
    end
  endtask

  logic [15:0] gd;
  logic        gb, gz, seen;
  int          lat, bcnt;
  logic [15:0] va[0:40];
  logic [15:0] vb[0:40];
  logic        vc[0:40];
  int          ndone;
  logic [15:0] ea;

  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    vecs[4] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_diff", 32'(diff), 32'd0);
    chk("reset_bout", 32'(bout), 32'd0);
    chk("reset_zero", 32'(zero), 32'd0);
    chk("reset_busy1", 32'(busy1), 32'd0);
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, gd, gb, gz, lat, bcnt, seen);
      chk($sformatf("vec%0d_seen", i), 32'(seen), 32'd1);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'd4);
      chk($sformatf("vec%0d_diff", i), 32'(gd), 32'(vecs[i].d));
      chk($sformatf("vec%0d_bout", i), 32'(gb), 32'(vecs[i].bo));
      chk($sformatf("vec%0d_zero", i), 32'(gz), 32'(vecs[i].z));
      @(negedge clk);
      chk($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("vec%0d_diff_hold", i), 32'(diff), 32'(vecs[i].d));
      chk($sformatf("vec%0d_zero_hold", i), 32'(zero), 32'(vecs[i].z));
    end

    // randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (i % 5 == 0) rb = ra;
      run_op(ra, rb, rc, gd, gb, gz, lat, bcnt, seen);
      chk($sformatf("rnd%0d_seen", i), 32'(seen), 32'd1);
      chk($sformatf("rnd%0d_diff", i), 32'(gd), 32'(ref_diff(ra, rb, rc)));
      chk($sformatf("rnd%0d_bout", i), 32'(gb), 32'(ref_bout(ra, rb, rc)));
      chk($sformatf("rnd%0d_zero", i), 32'(gz), 32'(ref_diff(ra, rb, rc) == 16'd0));
    end

    // start held high with changing operands: accepted edges 1, 7, 13, ...
    // values driven at negedge k are sampled at posedge k+1.
    @(negedge clk);
    @(negedge clk);
    ndone = 0;
    va[0] = 16'($urandom); vb[0] = 16'($urandom); vc[0] = 1'($urandom);
    a = va[0]; b = vb[0]; bin = vc[0]; start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk($sformatf("hold_done_time_k%0d", k), 32'((k - 5) % 6), 32'd0);
        if (k >= 5) begin
          ea = ref_diff(va[k-5], vb[k-5], vc[k-5]);
          chk($sformatf("hold_diff_k%0d", k), 32'(diff), 32'(ea));
          chk($sformatf("hold_bout_k%0d", k), 32'(bout), 32'(ref_bout(va[k-5], vb[k-5], vc[k-5])));
        end
      end
      va[k] = 16'($urandom); vb[k] = 16'($urandom); vc[k] = 1'($urandom);
      a = va[k]; b = vb[k]; bin = vc[k];
    end
    chk("hold_done_count", 32'(ndone), 32'd5);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // reset two cycles into RUN aborts the operation
    @(negedge clk);
    a = 16'h4321; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(bout), 32'd0);
    chk("abort_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op(16'h4321, 16'h1111, 1'b1, gd, gb, gz, lat, bcnt, seen);
    chk("after_abort_seen", 32'(seen), 32'd1);
    chk("after_abort_diff", 32'(gd), 32'h320F);
    chk("after_abort_bout", 32'(gb), 32'd0);

    // reset wins over start on the same edge
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; start = 1'b1; a = 16'h0001; b = 16'h0002;
    @(negedge clk);
    chk("rst_prio_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rst_prio_idle", 32'(busy), 32'd0);

    // exhaustive single-digit instance
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          int r;
          @(negedge clk);
          a1 = 4'(x); b1 = 4'(y); bin1 = 1'(c); start1 = 1'b1;
          @(negedge clk);
          start1 = 1'b0;
          a1 = 4'($urandom); b1 = 4'($urandom); bin1 = 1'($urandom);
          @(negedge clk);
          r = x - y - c;
          if (done1 !== 1'b1 || diff1 !== 4'(r & 15) || bout1 !== 1'(x < y + c)
              || zero1 !== 1'((r & 15) == 0)) begin
            chk($sformatf("n1_a%0d_b%0d_c%0d", x, y, c),
                {23'd0, done1, diff1, bout1, zero1, 2'd0},
                {23'd1, 4'(r & 15), 1'(x < y + c), 1'((r & 15) == 0), 2'd0});
          end else begin
            n_chk++;
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
